// File: rtl/div100_seq_pkg.sv
// Shared constants and state encoding for the x100 scaler and the sequential divider.
// Both blocks import these defaults so that their widths and divisor always match.
package div100_seq_pkg;

   localparam int DIV_IN_W    = 10;
   localparam int DIV_DIVISOR = 100;
   localparam int DIV_Q_W     = 4;
   localparam int DIV_R_W     = 7;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } div_state_e;

endpackage

// File: rtl/div100_seq.sv
// Sequential divide-by-DIVISOR using repeated subtraction, with a start/done handshake.
// Splits a scaled binary value into a saturating quotient and a sub-divisor remainder.
module div100_seq
   import div100_seq_pkg::*;
#(
   parameter int IN_W    = DIV_IN_W,
   parameter int DIVISOR = DIV_DIVISOR,
   parameter int Q_W     = DIV_Q_W,
   parameter int R_W     = DIV_R_W
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            Start_In,
   input  logic [IN_W-1:0] Value_In,
   output logic            Busy_Out,
   output logic            Done_Out,
   output logic [Q_W-1:0]  Quotient_Out,
   output logic [R_W-1:0]  Remainder_Out,
   output logic            Overflow_Out
);

   localparam logic [IN_W-1:0] DIV_V = IN_W'(DIVISOR);
   localparam logic [Q_W-1:0]  Q_MAX = '1;

   generate
      if ((DIVISOR < 1) || (DIVISOR >= (2 ** IN_W)) || ((2 ** R_W) < DIVISOR)) begin : g_bad_params
         $error("div100_seq: DIVISOR must be >= 1, below 2**IN_W and at most 2**R_W");
      end
   endgenerate

   div_state_e      state_q, state_d;
   logic [IN_W-1:0] acc_q, acc_d;
   logic [Q_W-1:0]  q_q, q_d;
   logic [Q_W-1:0]  quot_q, quot_d;
   logic [R_W-1:0]  rem_q, rem_d;
   logic            ovf_q, ovf_d;
   logic            done_q, done_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         q_q     <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   // Subtraction only happens when acc >= DIVISOR, so acc can never wrap below zero.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      q_d     = q_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      ovf_d   = ovf_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (Start_In) begin
               acc_d   = Value_In;
               q_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (acc_q < DIV_V) begin
               quot_d  = q_q;
               rem_d   = R_W'(acc_q);
               ovf_d   = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (q_q == Q_MAX) begin
               quot_d  = '1;
               rem_d   = '1;
               ovf_d   = 1'b1;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               acc_d = acc_q - DIV_V;
               q_d   = q_q + Q_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign Busy_Out      = (state_q == RUN);
   assign Done_Out      = done_q;
   assign Quotient_Out  = quot_q;
   assign Remainder_Out = rem_q;
   assign Overflow_Out  = ovf_q;

endmodule

// File: tb/tb_div100_seq.sv
// Self-checking bench for div100_seq: default divisor 100 and an override of 50,
// compared against a plain-arithmetic reference of quotient, remainder and latency.
module tb_div100_seq;

   logic       clk;
   logic       reset;
   logic       start1, start2;
   logic [9:0] value1, value2;
   logic       busy1, done1, ovf1, busy2, done2, ovf2;
   logic [3:0] quot1, quot2;
   logic [6:0] rem1, rem2;

   int errors = 0;
   int checks = 0;
   int exp_q[2];
   int exp_r[2];
   int exp_o[2];

   div100_seq dut1 (
      .clk(clk), .reset(reset), .Start_In(start1), .Value_In(value1),
      .Busy_Out(busy1), .Done_Out(done1), .Quotient_Out(quot1),
      .Remainder_Out(rem1), .Overflow_Out(ovf1)
   );

   div100_seq #(.DIVISOR(50)) dut2 (
      .clk(clk), .reset(reset), .Start_In(start2), .Value_In(value2),
      .Busy_Out(busy2), .Done_Out(done2), .Quotient_Out(quot2),
      .Remainder_Out(rem2), .Overflow_Out(ovf2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain division, saturating at a 4-bit quotient.
   function automatic void model(input int d, input int v, output int q, output int r,
                                 output int o, output int lat);
      q = v / d;
      r = v % d;
      o = 0;
      lat = ((q > 15) ? 15 : q) + 2;
      if (q > 15) begin
         q = 15;
         r = 127;
         o = 1;
      end
   endfunction

   task automatic drive(input bit s, input logic st, input logic [9:0] v);
      if (s) begin start2 = st; value2 = v; end
      else   begin start1 = st; value1 = v; end
   endtask

   task automatic sample(input bit s, output logic d, output logic b, output logic o,
                         output logic [3:0] q, output logic [6:0] r);
      d = s ? done2 : done1;
      b = s ? busy2 : busy1;
      o = s ? ovf2  : ovf1;
      q = s ? quot2 : quot1;
      r = s ? rem2  : rem1;
   endtask

   // Called just after an accepting edge; watches each cycle until Done.
   task automatic wait_done(input bit s, input int v, input bit chain, input logic [9:0] next_v);
      int q, r, o, lat;
      bit seen;
      logic d, b, oo;
      logic [3:0] qq;
      logic [6:0] rr;
      model(s ? 50 : 100, v, q, r, o, lat);
      seen = 0;
      for (int k = 1; k <= lat + 3 && !seen; k++) begin
         @(negedge clk);
         sample(s, d, b, oo, qq, rr);
         if (d) begin
            seen = 1;
            checks++;
            if (k != lat) begin
               errors++;
               $display("[TB] FAIL latency v=%0d: got %0d cycles, want %0d", v, k, lat);
            end
            checks++;
            if (qq !== 4'(q) || rr !== 7'(r) || oo !== 1'(o) || b !== 1'b0) begin
               errors++;
               $display("[TB] FAIL result v=%0d: got q=%0d r=%0d ovf=%b busy=%b, want q=%0d r=%0d ovf=%0d busy=0",
                        v, qq, rr, oo, b, q, r, o);
            end
            exp_q[s] = q;
            exp_r[s] = r;
            exp_o[s] = o;
            if (chain) drive(s, 1'b1, next_v);
         end else begin
            checks++;
            if (b !== 1'b1 || qq !== 4'(exp_q[s]) || rr !== 7'(exp_r[s]) || oo !== 1'(exp_o[s])) begin
               errors++;
               $display("[TB] FAIL hold v=%0d cyc=%0d: got busy=%b q=%0d r=%0d ovf=%b, want busy=1 q=%0d r=%0d ovf=%0d",
                        v, k, b, qq, rr, oo, exp_q[s], exp_r[s], exp_o[s]);
            end
            if (s) value2 = 10'($urandom);
            else   value1 = 10'($urandom);
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("[TB] FAIL timeout v=%0d: got no Done within %0d cycles, want Done at %0d", v, lat + 3, lat);
      end
   endtask

   task automatic run_op(input bit s, input int v);
      logic d, b, oo;
      logic [3:0] qq;
      logic [6:0] rr;
      drive(s, 1'b1, 10'(v));
      @(posedge clk);
      #1 drive(s, 1'b0, 10'($urandom));
      wait_done(s, v, 1'b0, 10'd0);
      @(negedge clk);
      sample(s, d, b, oo, qq, rr);
      checks++;
      if (d !== 1'b0 || b !== 1'b0) begin
         errors++;
         $display("[TB] FAIL pulse v=%0d: got done=%b busy=%b after Done, want 0 0", v, d, b);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(0, 1'b0, 10'd0);
      drive(1, 1'b0, 10'd0);
      repeat (3) @(negedge clk);
      checks++;
      if ({busy1, done1, ovf1, quot1, rem1, busy2, done2, ovf2, quot2, rem2} !== '0) begin
         errors++;
         $display("[TB] FAIL reset: got q1=%0d r1=%0d q2=%0d r2=%0d busy=%b%b done=%b%b, want all 0",
                  quot1, rem1, quot2, rem2, busy1, busy2, done1, done2);
      end
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin exp_q[i] = 0; exp_r[i] = 0; exp_o[i] = 0; end
      @(negedge clk);
   endtask

   task automatic test_directed();
      int vals[4] = '{0, 99, 100, 1023};
      foreach (vals[i]) run_op(0, vals[i]);
   endtask

   task automatic test_round_trip();
      for (int c = 0; c <= 10; c++) run_op(0, c * 100);
      for (int c = 0; c <= 9; c++) run_op(0, c * 100 + 37);
   endtask

   task automatic test_back_to_back();
      logic [9:0] v2;
      v2 = 10'd345;
      drive(0, 1'b1, 10'd512);
      @(posedge clk);
      #1 value1 = 10'($urandom);
      wait_done(0, 512, 1'b1, v2);
      @(posedge clk);
      #1 drive(0, 1'b0, 10'($urandom));
      wait_done(0, 345, 1'b0, 10'd0);
      @(negedge clk);
      checks++;
      if (done1 !== 1'b0 || busy1 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_idle: got done=%b busy=%b, want 0 0", done1, busy1);
      end
   endtask

   task automatic test_reset_mid_run();
      run_op(0, 1023);
      drive(0, 1'b1, 10'd900);
      @(posedge clk);
      #1 drive(0, 1'b0, 10'd0);
      repeat (3) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({busy1, done1, ovf1, quot1, rem1} !== '0) begin
         errors++;
         $display("[TB] FAIL abort: got busy=%b done=%b q=%0d r=%0d ovf=%b, want all 0",
                  busy1, done1, quot1, rem1, ovf1);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin exp_q[i] = 0; exp_r[i] = 0; exp_o[i] = 0; end
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         checks++;
         if (done1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_quiet cyc=%0d: got done=%b busy=%b, want 0 0", k, done1, busy1);
         end
      end
   endtask

   task automatic test_divisor50();
      run_op(1, 1023);
      run_op(1, 749);
      run_op(1, 799);
      run_op(1, 800);
      for (int i = 0; i < 10; i++) run_op(1, int'($urandom_range(0, 1023)));
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++) run_op(0, int'($urandom_range(0, 1023)));
   endtask

   initial begin
      test_reset();
      test_directed();
      test_round_trip();
      test_back_to_back();
      test_reset_mid_run();
      test_divisor50();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
